// File: rtl/simd_wb_pkg.sv
// Shared types and helpers for the N-lane SIMD result writer.
package simd_wb_pkg;

    localparam int unsigned MAX_LANES = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        WRITE,
        DONE
    } wb_state_t;

    // Lane k is active when it is a real lane and still inside the frame.
    function automatic logic [MAX_LANES-1:0] wb_lane_mask_f(input int unsigned remaining,
                                                            input int unsigned n);
        logic [MAX_LANES-1:0] mask;
        mask = '0;
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
            mask[k] = (k < n) && (k < remaining);
        end
        return mask;
    endfunction

endpackage

// File: rtl/simd_beat_reg.sv
// N-lane beat capture register with a lane-valid mask; inactive lanes are stored as zero.
module simd_beat_reg #(
    parameter int unsigned N     = 4,
    parameter int unsigned PIX_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [N-1:0][PIX_W-1:0]   load_data,
    input  logic [N-1:0]              load_mask,
    output logic [N-1:0][PIX_W-1:0]   data,
    output logic [N-1:0]              mask
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            mask <= '0;
        end else if (load) begin
            mask <= load_mask;
            for (int unsigned k = 0; k < N; k++) begin
                data[k] <= load_mask[k] ? load_data[k] : '0;
            end
        end
    end

endmodule

// File: rtl/simd_result_writer.sv
// Writes the downscaled frame to BRAM as N-lane SIMD beats starting at BASE_ADDR.
// Optional running pixel checksum output enabled by SIMD_WB_CHECKSUM_EN.
module simd_result_writer
    import simd_wb_pkg::*;
#(
    parameter int unsigned  DST_W     = 16,
    parameter int unsigned  DST_H     = 16,
    parameter int unsigned  N         = 4,
    parameter int unsigned  ADDR_BITS = 11,
    parameter int unsigned  BASE_ADDR = 1024,
    localparam int unsigned DEPTH     = DST_W * DST_H,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N-1:0][7:0]             in_data,
    output logic [N-1:0]                  wr_req,
    output logic [N-1:0][ADDR_BITS-1:0]   wr_addr,
    output logic [N-1:0][7:0]             wr_data,
    input  logic                          wr_ack,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              pix_count
`ifdef SIMD_WB_CHECKSUM_EN
    ,
    output logic [15:0]                   checksum
`endif
);

    localparam int unsigned PIX_W = 8;

    if (BASE_ADDR + DEPTH > 2 ** ADDR_BITS) begin : g_addr_range_check
        $error("simd_result_writer: output frame does not fit in the BRAM address space");
    end

    wb_state_t               state;
    logic [N-1:0][PIX_W-1:0] beat_data;
    logic [N-1:0]            beat_mask;
    logic [N-1:0]            load_mask_c;
    logic                    load_c;
    logic [CNT_W-1:0]        remaining_c;
    logic [CNT_W-1:0]        active_c;
    logic [CNT_W-1:0]        pix_next_c;

    assign remaining_c = CNT_W'(DEPTH) - pix_count;
    assign active_c    = (remaining_c < CNT_W'(N)) ? remaining_c : CNT_W'(N);
    assign pix_next_c  = pix_count + active_c;
    assign load_mask_c = N'(wb_lane_mask_f(32'(remaining_c), N));
    assign load_c      = (state == ACCEPT) && in_valid;

    simd_beat_reg #(
        .N     (N),
        .PIX_W (PIX_W)
    ) u_beat_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .load_data (in_data),
        .load_mask (load_mask_c),
        .data      (beat_data),
        .mask      (beat_mask)
    );

    assign wr_data = beat_data;

`ifdef SIMD_WB_CHECKSUM_EN
    logic [15:0] sum_c;

    // Running checksum including the beat currently held for write.
    always_comb begin
        sum_c = checksum;
        for (int unsigned k = 0; k < N; k++) begin
            if (beat_mask[k]) begin
                sum_c = sum_c + 16'(beat_data[k]);
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_count <= '0;
            wr_req    <= '0;
            wr_addr   <= '0;
`ifdef SIMD_WB_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ACCEPT;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                        pix_count <= '0;
`ifdef SIMD_WB_CHECKSUM_EN
                        checksum  <= '0;
`endif
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        state    <= WRITE;
                        in_ready <= 1'b0;
                        wr_req   <= load_mask_c;
                        for (int unsigned k = 0; k < N; k++) begin
                            wr_addr[k] <= ADDR_BITS'(BASE_ADDR + 32'(pix_count) + k);
                        end
                    end
                end
                WRITE: begin
                    if (wr_ack) begin
                        wr_req    <= '0;
                        pix_count <= pix_next_c;
`ifdef SIMD_WB_CHECKSUM_EN
                        checksum  <= sum_c;
`endif
                        if (pix_next_c == CNT_W'(DEPTH)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state    <= ACCEPT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simd_result_writer.sv
// Self-checking bench: a 16x16 and a 5x3 writer share stimulus, selected by sel,
// checked against a frame/memory model built from the writer's address and lane rules.
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); end end

module tb_simd_result_writer;

    localparam int unsigned N    = 4;
    localparam int unsigned AB   = 11;
    localparam int unsigned BASE = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic             wr_ack = 1'b0;
    logic [N-1:0][7:0] in_data = '0;
    logic             sel = 1'b0;

    logic a_ready, b_ready, a_busy, b_busy, a_done, b_done;
    logic [N-1:0] a_req, b_req;
    logic [N-1:0][AB-1:0] a_addr, b_addr;
    logic [N-1:0][7:0] a_wdata, b_wdata;
    logic [8:0] a_cnt;
    logic [3:0] b_cnt;
    logic [15:0] a_sum, b_sum;

    simd_result_writer u_a (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .in_valid(in_valid), .in_ready(a_ready),
        .in_data(in_data), .wr_req(a_req), .wr_addr(a_addr), .wr_data(a_wdata), .wr_ack(wr_ack),
        .busy(a_busy), .done(a_done), .pix_count(a_cnt)
`ifdef SIMD_WB_CHECKSUM_EN
        , .checksum(a_sum)
`endif
    );

    simd_result_writer #(.DST_W(5), .DST_H(3)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .in_valid(in_valid), .in_ready(b_ready),
        .in_data(in_data), .wr_req(b_req), .wr_addr(b_addr), .wr_data(b_wdata), .wr_ack(wr_ack),
        .busy(b_busy), .done(b_done), .pix_count(b_cnt)
`ifdef SIMD_WB_CHECKSUM_EN
        , .checksum(b_sum)
`endif
    );

`ifndef SIMD_WB_CHECKSUM_EN
    assign a_sum = '0;
    assign b_sum = '0;
`endif

    logic o_ready, o_busy, o_done;
    logic [N-1:0] o_req;
    logic [N-1:0][AB-1:0] o_addr;
    logic [N-1:0][7:0] o_wdata;
    logic [31:0] o_cnt;
    logic [15:0] o_sum;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;
    assign o_req   = sel ? b_req   : a_req;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_wdata = sel ? b_wdata : a_wdata;
    assign o_cnt   = sel ? 32'(b_cnt) : 32'(a_cnt);
    assign o_sum   = sel ? b_sum   : a_sum;

    int errors = 0;
    int checks = 0;

    // Memory model: every acknowledged active lane lands at its address.
    logic [7:0] mem [2048];
    bit         written [2048];
    int         replays = 0;
    logic [7:0] frame [256];

    always @(posedge clk) begin
        if (rst_n && wr_ack) begin
            for (int k = 0; k < N; k++) begin
                if (o_req[k]) begin
                    if (written[o_addr[k]]) replays++;
                    written[o_addr[k]] = 1'b1;
                    mem[o_addr[k]] = o_wdata[k];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string where);
        `CHK(where, {o_ready, o_busy, o_done, o_req}, 7'd0)
        `CHK("reset_addr", o_addr, 44'd0)
        `CHK("reset_data", o_wdata, 32'd0)
        `CHK("reset_count", o_cnt, 32'd0)
`ifdef SIMD_WB_CHECKSUM_EN
        `CHK("reset_checksum", o_sum, 16'd0)
`endif
    endtask

    // fill: -2 index pattern, -1 random, else constant. ack_wait < 0 picks a random wait per beat.
    task automatic run_frame(input int depth, input int ack_wait, input int fill,
                             input int abort_beat, input int exp_cycles);
        int pix, beat, cycles, wait_n, bad;
        logic [15:0] exp_sum;
        logic [N-1:0] exp_req;
        pix = 0; beat = 0; cycles = 0; exp_sum = '0;
        for (int a = 0; a < 2048; a++) begin
            written[a] = 1'b0;
            mem[a] = '0;
        end
        replays = 0;
        for (int i = 0; i < depth; i++) begin
            frame[i] = (fill == -2) ? 8'(i) : (fill == -1) ? 8'($urandom) : 8'(fill);
            exp_sum = exp_sum + 16'(frame[i]);
        end
        start = 1'b1;
        tick();
        `CHK("busy_after_start", o_busy, 1'b1)
        `CHK("count_cleared", o_cnt, 32'd0)
        while (pix < depth && cycles < 4000) begin
            `CHK("in_ready_accept", o_ready, 1'b1)
            for (int k = 0; k < N; k++) begin
                in_data[k] = (pix + k < depth) ? frame[pix + k] : 8'($urandom);
                exp_req[k] = (pix + k < depth);
            end
            in_valid = 1'b1;
            wr_ack = 1'b0;
            tick(); cycles++;
            in_valid = 1'b0;
            wait_n = (ack_wait < 0) ? int'($urandom_range(0, 3)) : ack_wait;
            for (int w = 0; w <= wait_n; w++) begin
                `CHK("in_ready_write", o_ready, 1'b0)
                `CHK("wr_req", o_req, exp_req)
                for (int k = 0; k < N; k++) begin
                    if (exp_req[k]) begin
                        `CHK("wr_addr", o_addr[k], AB'(BASE + pix + k))
                        `CHK("wr_data", o_wdata[k], frame[pix + k])
                    end
                end
                if (beat == abort_beat && w == 1) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    tick();
                    check_all_zero("abort_outputs");
                    rst_n = 1'b1;
                    tick();
                    return;
                end
                wr_ack = (w == wait_n);
                tick(); cycles++;
            end
            wr_ack = 1'b0;
            pix += (depth - pix < N) ? depth - pix : N;
            beat++;
        end
        `CHK("frame_within_budget", pix, depth)
        `CHK("done_after_last_ack", o_done, 1'b1)
        `CHK("busy_in_done", o_busy, 1'b0)
        `CHK("pix_count_final", o_cnt, 32'(depth))
`ifdef SIMD_WB_CHECKSUM_EN
        `CHK("checksum", o_sum, exp_sum)
`endif
        if (exp_cycles >= 0) begin
            `CHK("frame_cycles", cycles, exp_cycles)
        end
        bad = 0;
        for (int a = 0; a < 2048; a++) begin
            if (written[a] != (a >= BASE && a < BASE + depth)) bad++;
            else if (written[a] && mem[a] !== frame[a - BASE]) bad++;
        end
        `CHK("mem_image", bad, 0)
        `CHK("no_replays", replays, 0)
        // start held high in DONE: no restart, no writes
        in_valid = 1'b1;
        wr_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            `CHK("done_held", o_done, 1'b1)
            `CHK("no_write_in_done", o_req, 4'd0)
        end
        in_valid = 1'b0;
        wr_ack = 1'b0;
        start = 1'b0;
        tick();
        `CHK("done_cleared", o_done, 1'b0)
        `CHK("count_held_idle", o_cnt, 32'(depth))
    endtask

    initial begin
        tick();
        tick();
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        tick();

        sel = 1'b0;
        run_frame(256, 0, -2, -1, 128);
        run_frame(256, 3, -1, -1, 320);

        sel = 1'b1;
        run_frame(15, 0, -1, -1, 8);
        run_frame(15, 2, -1, -1, 16);

        sel = 1'b0;
        run_frame(256, 2, -1, 10, -1);
        run_frame(256, -1, -1, -1, -1);
        run_frame(256, 0, 255, -1, 128);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
